// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: walks a pixel RAM, hands brightness-scaled pixels to a
// bit serializer, then holds the line-reset (latch) period and optionally repeats.
module ws2812_frame_sched #(
    parameter int NUM_LEDS     = 8,
    parameter int RESET_CYCLES = 15000,
    parameter int GAP_CYCLES   = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
    input  logic [23:0]                 wr_rgb,
    input  logic [7:0]                  brightness,
    input  logic                        start,
    input  logic                        auto_en,
    input  logic                        tx_done,
    output logic                        tx_start,
    output logic [23:0]                 tx_rgb,
    output logic                        line_reset,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int AW      = $clog2(NUM_LEDS);
    localparam int CNT_MAX = (RESET_CYCLES > GAP_CYCLES) ? RESET_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [23:0]   ram_q [NUM_LEDS];

    logic [1:0]    state_q,      state_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [7:0]    bright_q,     bright_d;
    logic          tx_start_q,   tx_start_d;
    logic [23:0]   tx_rgb_q,     tx_rgb_d;
    logic          frame_done_q, frame_done_d;

    logic [AW-1:0] idx_next;
    logic          launch;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_rgb(input logic [23:0] px, input logic [7:0] b);
        return {scale_ch(px[23:16], b), scale_ch(px[15:8], b), scale_ch(px[7:0], b)};
    endfunction

    // Pixel RAM: writable in every state; out-of-range addresses are dropped.
    // NOTE: the array is plain flops, so it takes the async reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                ram_q[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < NUM_LEDS)) begin
            ram_q[wr_addr] <= wr_rgb;
        end
    end

    assign idx_next = idx_q + AW'(1);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        bright_d     = bright_q;
        tx_start_d   = 1'b0;
        tx_rgb_d     = tx_rgb_q;
        frame_done_d = 1'b0;
        launch       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_en) begin
                    launch = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_LATCH;
                        cnt_d   = '0;
                    end else begin
                        idx_d      = idx_next;
                        tx_start_d = 1'b1;
                        tx_rgb_d   = scale_rgb(ram_q[idx_next], bright_q);
                    end
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = auto_en ? ST_GAP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // GAP spans the frame_done cycle plus GAP_CYCLES idle clocks.
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (auto_en) begin
                        launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        // Frame start scales pixel 0 with the live brightness, which is latched in the same edge.
        if (launch) begin
            state_d    = ST_SEND;
            idx_d      = '0;
            cnt_d      = '0;
            bright_d   = brightness;
            tx_start_d = 1'b1;
            tx_rgb_d   = scale_rgb(ram_q[0], brightness);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            bright_q     <= '0;
            tx_start_q   <= 1'b0;
            tx_rgb_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            bright_q     <= bright_d;
            tx_start_q   <= tx_start_d;
            tx_rgb_q     <= tx_rgb_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_rgb     = tx_rgb_q;
    assign frame_done = frame_done_q;
    assign line_reset = (state_q == ST_LATCH);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench for ws2812_frame_sched: a serializer model answers every
// tx_start with tx_done, and a scoreboard queue holds the expected tx_rgb stream.
module tb_ws2812_frame_sched;

    localparam int NUM_LEDS     = 4;
    localparam int RESET_CYCLES = 20;
    localparam int GAP_CYCLES   = 30;
    localparam int SER_LAT      = 3;
    localparam int BUDGET       = 1000;
    // First tx_start cycle to frame_done cycle.
    localparam int FRAME_LEN    = (NUM_LEDS - 1) * (SER_LAT + 1) + SER_LAT + 1 + RESET_CYCLES;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic [7:0]  brightness;
    logic        start;
    logic        auto_en;
    logic        tx_done;
    logic        tx_start;
    logic [23:0] tx_rgb;
    logic        line_reset;
    logic        busy;
    logic        frame_done;

    logic        ser_done  = 1'b0;
    logic        spur_done = 1'b0;
    assign tx_done = ser_done | spur_done;

    int n_cmp;
    int n_fail;
    int cyc;
    int ser_cnt;
    int n_starts;
    int n_adj;
    int done_cyc = -10;
    int lr_run;
    int lr_last;

    logic [23:0] exp_q [$];
    logic [23:0] mon_exp;
    logic [23:0] pix [NUM_LEDS];

    ws2812_frame_sched #(
        .NUM_LEDS    (NUM_LEDS),
        .RESET_CYCLES(RESET_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_rgb    (wr_rgb),
        .brightness(brightness),
        .start     (start),
        .auto_en   (auto_en),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_rgb    (tx_rgb),
        .line_reset(line_reset),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] exp_scale(input logic [23:0] px, input int b);
        int r, g, bl;
        r  = (int'(px[23:16]) * (b + 1)) / 256;
        g  = (int'(px[15:8])  * (b + 1)) / 256;
        bl = (int'(px[7:0])   * (b + 1)) / 256;
        return {r[7:0], g[7:0], bl[7:0]};
    endfunction

    // Serializer model + scoreboard, both sampled on the falling edge.
    always @(negedge clk) begin
        ser_done = (ser_cnt == 1);
        if (ser_done) done_cyc = cyc;
        if (ser_cnt > 0) ser_cnt--;
        if (tx_start === 1'b1) begin
            n_starts++;
            if (cyc == done_cyc + 1) n_adj++;
            ser_cnt = SER_LAT;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_rgb_extra: got tx_start with %06h at cycle %0d, required no tx_start", tx_rgb, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_rgb !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_rgb: got %06h, required %06h at cycle %0d", tx_rgb, mon_exp, cyc);
                end
            end
        end
        if (line_reset === 1'b1) begin
            lr_run++;
        end else begin
            if (lr_run != 0) lr_last = lr_run;
            lr_run = 0;
        end
    end

    task automatic write_px(input int a, input logic [23:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 2'(a);
        wr_rgb  = v;
        @(negedge clk);
        wr_en   = 1'b0;
        pix[a]  = v;
    endtask

    task automatic push_frame(input int b);
        for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(exp_scale(pix[i], b));
    endtask

    task automatic launch_frame(input string name, output int t0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        n_cmp++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start_latency: got tx_start=%b one cycle after start, required 1", name, tx_start);
        end
    endtask

    task automatic wait_start(input string name, output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_wait_tx_start: got timeout after %0d cycles, required a tx_start", name, BUDGET);
        end
    endtask

    task automatic wait_fd(input string name, output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_wait_frame_done: got timeout after %0d cycles, required frame_done", name, BUDGET);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({tx_start, tx_rgb, line_reset, busy, frame_done} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %07h, required 0000000", {tx_start, tx_rgb, line_reset, busy, frame_done});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tx_start, busy, frame_done, line_reset} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b, required 0000", {tx_start, busy, frame_done, line_reset});
        end
    endtask

    task automatic test_basic();
        int t0, fd, s0, a0;
        write_px(0, 24'hFF00FF);
        write_px(1, 24'h00FF00);
        write_px(2, 24'hAA55AA);
        write_px(3, 24'hA543D5);
        brightness = 8'd255;
        exp_q.push_back(24'hFF00FF);
        exp_q.push_back(24'h00FF00);
        exp_q.push_back(24'hAA55AA);
        exp_q.push_back(24'hA543D5);
        s0 = n_starts;
        a0 = n_adj;
        launch_frame("basic", t0);
        wait_fd("basic", fd);
        n_cmp++;
        if (fd - t0 != FRAME_LEN) begin
            n_fail++;
            $display("FAIL basic_frame_len: got %0d cycles, required %0d", fd - t0, FRAME_LEN);
        end
        n_cmp++;
        if (line_reset !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_state: got line_reset=%b busy=%b, required 0 0", line_reset, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (lr_last != RESET_CYCLES) begin
            n_fail++;
            $display("FAIL basic_line_reset_len: got %0d, required %0d", lr_last, RESET_CYCLES);
        end
        n_cmp++;
        if (n_starts - s0 != NUM_LEDS || n_adj - a0 != NUM_LEDS - 1) begin
            n_fail++;
            $display("FAIL basic_tx_count: got %0d starts (%0d after tx_done), required %0d (%0d)",
                     n_starts - s0, n_adj - a0, NUM_LEDS, NUM_LEDS - 1);
        end
        n_cmp++;
        if (frame_done !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_after: got frame_done=%b pending=%0d, required 0 0", frame_done, exp_q.size());
        end
    endtask

    task automatic test_scale();
        int t0, fd;
        write_px(0, 24'hFF8001);
        write_px(1, 24'h123456);
        write_px(2, 24'hFFFFFF);
        write_px(3, 24'h80C0FE);
        brightness = 8'd127;
        exp_q.push_back(24'h7F4000);
        for (int i = 1; i < NUM_LEDS; i++) exp_q.push_back(exp_scale(pix[i], 127));
        launch_frame("scale127", t0);
        brightness = 8'd0;
        wait_fd("scale127", fd);
        push_frame(0);
        launch_frame("scale0", t0);
        wait_fd("scale0", fd);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scale_pending: got %0d unsent pixels, required 0", exp_q.size());
        end
    endtask

    task automatic test_auto();
        int f1, t1, f2, s0;
        brightness = 8'd255;
        push_frame(255);
        push_frame(255);
        @(negedge clk);
        auto_en = 1'b1;
        wait_fd("auto1", f1);
        @(negedge clk);
        spur_done = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        start     = 1'b0;
        wait_start("auto_gap", t1);
        n_cmp++;
        if (t1 - f1 != GAP_CYCLES + 1) begin
            n_fail++;
            $display("FAIL auto_gap_len: got %0d cycles, required %0d", t1 - f1, GAP_CYCLES + 1);
        end
        wait_fd("auto2", f2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_gap_busy: got busy=%b, required 1", busy);
        end
        repeat (3) @(negedge clk);
        auto_en = 1'b0;
        s0 = n_starts;
        repeat (GAP_CYCLES + 10) @(negedge clk);
        n_cmp++;
        if (n_starts != s0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_stop: got %0d new starts busy=%b, required 0 0", n_starts - s0, busy);
        end
    endtask

    task automatic test_ignore();
        int t0, fd, s0;
        bit lr_seen = 1'b0;
        push_frame(255);
        s0 = n_starts;
        launch_frame("ignore", t0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < BUDGET && !lr_seen; i++) begin
            @(negedge clk);
            if (line_reset === 1'b1) lr_seen = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
            @(negedge clk);
        end
        wait_fd("ignore", fd);
        n_cmp++;
        if (fd - t0 != FRAME_LEN) begin
            n_fail++;
            $display("FAIL ignore_frame_len: got %0d cycles, required %0d", fd - t0, FRAME_LEN);
        end
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (n_starts - s0 != NUM_LEDS || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_starts: got %0d starts busy=%b, required %0d 0", n_starts - s0, busy, NUM_LEDS);
        end
    endtask

    task automatic test_same_cycle();
        int t0, t1, fd;
        push_frame(255);
        launch_frame("same_old", t0);
        wait_start("same_px1", t1);
        repeat (SER_LAT) @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_rgb  = 24'h0C0FFE;
        @(negedge clk);
        wr_en   = 1'b0;
        pix[2]  = 24'h0C0FFE;
        wait_fd("same_old", fd);
        push_frame(255);
        launch_frame("same_new", t0);
        wait_fd("same_new", fd);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL same_pending: got %0d unsent pixels, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1, fd, s0, fd_cnt;
        exp_q.push_back(exp_scale(pix[0], 255));
        exp_q.push_back(exp_scale(pix[1], 255));
        launch_frame("rstmid", t0);
        wait_start("rstmid_px1", t1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_start, tx_rgb, line_reset, busy, frame_done} !== 28'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %07h, required 0000000", {tx_start, tx_rgb, line_reset, busy, frame_done});
        end
        @(negedge clk);
        rst = 1'b0;
        s0 = n_starts;
        fd_cnt = 0;
        for (int i = 0; i < 4 * SER_LAT + RESET_CYCLES; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_cnt++;
        end
        n_cmp++;
        if (n_starts != s0 || fd_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got %0d starts %0d frame_done busy=%b, required 0 0 0",
                     n_starts - s0, fd_cnt, busy);
        end
        for (int i = 0; i < NUM_LEDS; i++) pix[i] = 24'h000000;
        push_frame(255);
        launch_frame("rstmid_zero", t0);
        wait_fd("rstmid_zero", fd);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_pending: got %0d unsent pixels, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_rgb     = '0;
        brightness = '0;
        start      = 1'b0;
        auto_en    = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) pix[i] = 24'h000000;

        test_reset();
        test_basic();
        test_scale();
        test_auto();
        test_ignore();
        test_same_cycle();
        test_reset_mid();

        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_pending: got %0d unsent pixels, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
